ring_johnson_counter: RTL
=========================

// Module: ring_johnson_counter
// PURPOSE
//  Parametrised WIDTH-bit shift counter for the user project area.
//  Runs in ring (one-hot) or Johnson (twisted-ring) mode, shifting left or right.
//  An internal prescaler sets the step rate; a parallel load is provided.
//  Detects illegal codes and can optionally self-correct them.
//  Drives io_out / la_data_out from user_proj_example; controlled from LA or wishbone registers.
// PARAMETERS
//  WIDTH       4   counter width in bits, >= 2
//  PRESCALE_W  16  prescaler compare width
//  AUTOCORRECT 1   1: a tick taken from an illegal state loads HOME; 0: illegal state shifts as-is
// PORTS
//  wb_clk_i    in  1           single clock, all logic on its rising edge
//  wb_rst_n_i  in  1           reset, synchronous, active-low
//  en_i        in  1           prescaler/count enable
//  mode_i      in  1           0 = ring, 1 = Johnson
//  dir_i       in  1           0 = left (towards MSB), 1 = right
//  load_i      in  1           parallel load strobe
//  load_val_i  in  WIDTH       value written on load
//  div_i       in  PRESCALE_W  a tick occurs every div_i+1 enabled cycles
//  count_o     out WIDTH       counter state (registered)
//  tick_o      out 1           1-cycle pulse: count_o updated by a shift this cycle
//  wrap_o      out 1           1-cycle pulse: a shift produced HOME
//  err_o       out 1           level: count_o is illegal for the current mode_i
// BEHAVIOUR
//  - HOME = {{WIDTH-1{1'b0}},1'b1}. HOME is legal in both modes.
//  - Reset (wb_rst_n_i=0 at a rising edge): count_o=HOME; prescaler count pre=0;
//    tick_o=0, wrap_o=0, err_o=0.
//  - Priority: reset > load > tick.
//  - Prescaler
//    - Advances only when en_i=1; with en_i=0, pre and count_o hold.
//    - Tick condition: en_i & (pre >= div_i). On a tick, pre<=0; otherwise pre<=pre+1.
//    - Use >= so that lowering div_i mid-count ticks on the next enabled cycle.
//    - div_i=0: one tick per enabled cycle.
//  - Tick, shift rules:
//    - ring left  : {c[W-2:0],c[W-1]}
//    - ring right : {c[0],c[W-1:1]}
//    - Johnson left : {c[W-2:0],~c[W-1]}
//    - Johnson right: {~c[0],c[W-1:1]}
//    - count_o, tick_o=1 and wrap_o update on the same edge (latency 0 from tick condition).
//  - Correction: if AUTOCORRECT=1 and the current state is illegal at a tick:
//    next count_o=HOME, tick_o=1, wrap_o=0.
//  - Load (load_i=1): count_o<=load_val_i; pre<=0; tick_o=0; wrap_o=0.
//    Load applies regardless of en_i; any value is accepted, including illegal codes.
//  - wrap_o = tick & shifted result == HOME. Never asserted on a load or a correction.
//  - Wrap period from HOME: WIDTH ticks in ring mode, 2*WIDTH ticks in Johnson mode.
//  - Legality of count_o:
//    - ring: popcount==1.
//    - Johnson: at most one i in [0,W-2] with c[i]!=c[i+1].
//  - err_o is registered: it reflects the count_o and mode_i from the previous edge,
//    i.e. it is valid one cycle after count_o changes.
//  - mode_i/dir_i changes take effect at the next tick; no state is modified on a change.
//    Example: ring 0010 -> Johnson gives err_o=1.
// STRUCTURE
//  - Package ring_cnt_pkg:
//    - MODE_RING/MODE_JOHNSON, DIR_LEFT/DIR_RIGHT constants
//    - function home(width)
//    - functions is_legal_ring / is_legal_johnson
//  - Sub-module ring_cnt_prescaler (en_i, div_i, clear -> tick); the clear input is driven by load.
//  - Shift, legality and flag logic stay in the top module.
// TESTING  (WIDTH=4, AUTOCORRECT=1 unless stated)
//  1. Reset; ring, left, div=0, en=1 -> count_o 0001,0010,0100,1000,0001;
//     wrap_o only on the 4th tick; err_o stays 0.
//  2. Johnson, left, div=0 -> 0001,0011,0111,1111,1110,1100,1000,0000,0001;
//     wrap_o on the 8th tick only.
//  3. Ring, right, div=2 -> tick_o every 3rd cycle: 0001->1000->0100;
//     en=0 for 2 cycles mid-count delays the next tick by exactly 2 cycles.
//  4. Ring, load 0110 -> err_o=1 next cycle; next tick -> count_o=0001, wrap_o=0,
//     err_o=0 a cycle later. With AUTOCORRECT=0 the same tick gives 1100, err_o stays 1.
//  5. Mid-count, reset low together with load_i=1 and a tick -> count_o=0001,
//     tick_o=0, wrap_o=0, pre=0.
//     Next: load_i=1 with tick condition true -> load wins, tick_o=0.
//  6. div=5, pre=4, div_i changed to 1 -> tick on the next enabled cycle, then every 2 cycles.

Source files
------------

// File: rtl/ring_cnt_pkg.sv
// Shared constants and code-legality helpers for the ring/Johnson shift counter.
// Helpers take a MAX_W-wide vector plus the live width so any WIDTH <= MAX_W works.
package ring_cnt_pkg;

    localparam int MAX_W = 64;

    localparam logic MODE_RING    = 1'b0;
    localparam logic MODE_JOHNSON = 1'b1;
    localparam logic DIR_LEFT     = 1'b0;
    localparam logic DIR_RIGHT    = 1'b1;

    typedef logic [MAX_W-1:0] cnt_vec_t;

    function automatic cnt_vec_t home(input int width);
        home = {{(MAX_W-1){1'b0}}, (width > 0)};
    endfunction

    function automatic logic is_legal_ring(input cnt_vec_t c, input int width);
        int ones;
        ones = 0;
        for (int i = 0; i < MAX_W; i++) begin
            ones = ones + (((i < width) && c[i]) ? 1 : 0);
        end
        is_legal_ring = (ones == 1);
    endfunction

    // Johnson codes are a single run of ones: at most one adjacent-bit transition.
    function automatic logic is_legal_johnson(input cnt_vec_t c, input int width);
        int trans;
        trans = 0;
        for (int i = 0; i < MAX_W - 1; i++) begin
            trans = trans + (((i < width - 1) && (c[i] != c[i+1])) ? 1 : 0);
        end
        is_legal_johnson = (trans <= 1);
    endfunction

endpackage

// File: rtl/ring_cnt_prescaler.sv
// Step-rate prescaler: ticks every div_i+1 enabled cycles; clear_i restarts the count.
import ring_cnt_pkg::*;

module ring_cnt_prescaler #(
    parameter int PRESCALE_W = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  en_i,
    input  logic                  clear_i,
    input  logic [PRESCALE_W-1:0] div_i,
    output logic                  tick_o
);

    logic [PRESCALE_W-1:0] pre_q;
    logic [PRESCALE_W-1:0] pre_d;

    // >= rather than == so a lowered div_i fires on the very next enabled cycle.
    assign tick_o = en_i & (pre_q >= div_i);

    always_comb begin
        pre_d = pre_q;
        if (clear_i) begin
            pre_d = '0;
        end else if (tick_o) begin
            pre_d = '0;
        end else if (en_i) begin
            pre_d = pre_q + PRESCALE_W'(1);
        end else begin
            pre_d = pre_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_d;
        end
    end

endmodule

// File: rtl/ring_johnson_counter.sv
// WIDTH-bit ring / Johnson shift counter with prescaled stepping, parallel load,
// illegal-code detection and optional self-correction back to HOME.
import ring_cnt_pkg::*;

module ring_johnson_counter #(
    parameter int WIDTH       = 4,
    parameter int PRESCALE_W  = 16,
    parameter int AUTOCORRECT = 1
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_n_i,
    input  logic                  en_i,
    input  logic                  mode_i,
    input  logic                  dir_i,
    input  logic                  load_i,
    input  logic [WIDTH-1:0]      load_val_i,
    input  logic [PRESCALE_W-1:0] div_i,
    output logic [WIDTH-1:0]      count_o,
    output logic                  tick_o,
    output logic                  wrap_o,
    output logic                  err_o
);

    localparam logic [WIDTH-1:0] HOME = WIDTH'(home(WIDTH));

    logic [WIDTH-1:0] count_q, count_d;
    logic             tick_q, tick_d;
    logic             wrap_q, wrap_d;
    logic             err_q;
    logic [WIDTH-1:0] shift_s;
    logic             legal_s;
    logic             step_s;

    ring_cnt_prescaler #(
        .PRESCALE_W (PRESCALE_W)
    ) u_prescaler (
        .clk_i   (wb_clk_i),
        .rst_n_i (wb_rst_n_i),
        .en_i    (en_i),
        .clear_i (load_i),
        .div_i   (div_i),
        .tick_o  (step_s)
    );

    assign legal_s = (mode_i == MODE_JOHNSON) ? is_legal_johnson(MAX_W'(count_q), WIDTH)
                                              : is_legal_ring(MAX_W'(count_q), WIDTH);

    always_comb begin
        shift_s = count_q;
        case ({mode_i, dir_i})
            {MODE_RING,    DIR_LEFT }: shift_s = {count_q[WIDTH-2:0], count_q[WIDTH-1]};
            {MODE_RING,    DIR_RIGHT}: shift_s = {count_q[0], count_q[WIDTH-1:1]};
            {MODE_JOHNSON, DIR_LEFT }: shift_s = {count_q[WIDTH-2:0], ~count_q[WIDTH-1]};
            {MODE_JOHNSON, DIR_RIGHT}: shift_s = {~count_q[0], count_q[WIDTH-1:1]};
            default:                   shift_s = count_q;
        endcase
    end

    // Load beats a tick; a tick from an illegal code corrects to HOME without flagging a wrap.
    always_comb begin
        count_d = count_q;
        tick_d  = 1'b0;
        wrap_d  = 1'b0;
        if (load_i) begin
            count_d = load_val_i;
        end else if (step_s) begin
            tick_d = 1'b1;
            if ((AUTOCORRECT != 0) && !legal_s) begin
                count_d = HOME;
            end else begin
                count_d = shift_s;
                wrap_d  = (shift_s == HOME);
            end
        end else begin
            count_d = count_q;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n_i) begin
            count_q <= HOME;
            tick_q  <= 1'b0;
            wrap_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            tick_q  <= tick_d;
            wrap_q  <= wrap_d;
            err_q   <= ~legal_s;
        end
    end

    assign count_o = count_q;
    assign tick_o  = tick_q;
    assign wrap_o  = wrap_q;
    assign err_o   = err_q;

endmodule
